// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master engine among NUM_REQ
// requesters: one addressed byte per grant, with an engine-completion timeout.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_wdata,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata,
  input  logic                 m_ack_err
);

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                m_start_q, m_start_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic                m_rw_q, m_rw_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic [ID_W-1:0]     pick;
  logic                pick_found;
  logic                accept;
  int unsigned         idx;
  logic [NUM_REQ-1:0]  rot;

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    rot        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(last_grant_q) + 32'd1 + i) % NUM_REQ;
      rot = req_valid >> idx;
      if (!pick_found && rot[0]) begin
        pick       = ID_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign accept    = (state_q == IDLE) && !m_busy && pick_found;
  assign req_ready = accept ? (NUM_REQ'(1) << pick) : '0;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    m_start_d    = 1'b0;
    m_addr_d     = m_addr_q;
    m_rw_d       = m_rw_q;
    m_wdata_d    = m_wdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          m_addr_d   = ADDR_W'(req_addr >> (32'(pick) * ADDR_W));
          m_wdata_d  = DATA_W'(req_wdata >> (32'(pick) * DATA_W));
          m_rw_d     = 1'((req_rw >> pick));
          grant_id_d = pick;
          m_start_d  = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = TIMEOUT;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the final counted cycle still beats the timeout.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (m_done) begin
          rsp_rdata_d = m_rw_q ? m_rdata : '0;
          rsp_err_d   = m_ack_err ? ERR_NACK : ERR_OK;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          state_d     = RESP;
        end else if (cnt_q <= CNT_W'(1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_TO;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      cnt_q        <= '0;
      m_start_q    <= 1'b0;
      m_addr_q     <= '0;
      m_rw_q       <= 1'b0;
      m_wdata_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= ERR_OK;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      m_start_q    <= m_start_d;
      m_addr_q     <= m_addr_d;
      m_rw_q       <= m_rw_d;
      m_wdata_q    <= m_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign m_start   = m_start_q;
  assign m_addr    = m_addr_q;
  assign m_rw      = m_rw_q;
  assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter; the engine side is driven by hand with
// TIMEOUT=100 so timeout and done-at-expiry cases stay short.
module tb_i2c_bus_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*7-1:0] req_addr;
  logic [NUM_REQ-1:0]   req_rw;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_rdata;
  logic [1:0]           rsp_err;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 m_start;
  logic [6:0]           m_addr;
  logic                 m_rw;
  logic [7:0]           m_wdata;
  logic                 m_busy;
  logic                 m_done;
  logic [7:0]           m_rdata;
  logic                 m_ack_err;

  int checks   = 0;
  int failures = 0;

  i2c_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (16'd100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .grant_id  (grant_id),
    .busy      (busy),
    .m_start   (m_start),
    .m_addr    (m_addr),
    .m_rw      (m_rw),
    .m_wdata   (m_wdata),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_rdata   (m_rdata),
    .m_ack_err (m_ack_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_rw    = '0;
    req_wdata = '0;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_rdata   = '0;
    m_ack_err = 1'b0;
    step(2);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Single write from requester 0.
    req_valid = 4'b0001;
    req_addr[6:0]  = 7'h50;
    req_wdata[7:0] = 8'hA5;
    req_rw[0]      = 1'b0;
    #1;
    check("w_ready", 32'(req_ready), 32'h1);
    step();
    check("w_m_start", 32'(m_start), 32'd1);
    check("w_m_addr", 32'(m_addr), 32'h50);
    check("w_m_wdata", 32'(m_wdata), 32'hA5);
    check("w_m_rw", 32'(m_rw), 32'd0);
    check("w_grant", 32'(grant_id), 32'd0);
    check("w_busy", 32'(busy), 32'd1);
    req_valid = '0;
    req_addr  = '1;
    req_wdata = '1;
    step();
    check("w_m_start_pulse", 32'(m_start), 32'd0);
    check("w_m_addr_hold", 32'(m_addr), 32'h50);
    check("w_ready_wait", 32'(req_ready), 32'd0);
    step(18);
    m_done  = 1'b1;
    m_rdata = 8'hFF;
    step();
    m_done = 1'b0;
    check("w_rsp_valid", 32'(rsp_valid), 32'h1);
    check("w_rsp_err", 32'(rsp_err), 32'd0);
    check("w_rsp_rdata", 32'(rsp_rdata), 32'h00);
    step();
    check("w_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("w_idle_busy", 32'(busy), 32'd0);

    // Read with NACK from requester 2.
    req_addr  = '0;
    req_wdata = '0;
    req_valid = 4'b0100;
    req_addr[20:14] = 7'h1E;
    req_rw    = 4'b0100;
    #1;
    check("r_ready", 32'(req_ready), 32'h4);
    step();
    check("r_grant", 32'(grant_id), 32'd2);
    check("r_m_addr", 32'(m_addr), 32'h1E);
    check("r_m_rw", 32'(m_rw), 32'd1);
    req_valid = '0;
    step();
    m_done    = 1'b1;
    m_rdata   = 8'h3C;
    m_ack_err = 1'b1;
    step();
    m_done    = 1'b0;
    m_ack_err = 1'b0;
    check("r_rsp_valid", 32'(rsp_valid), 32'h4);
    check("r_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    check("r_rsp_err", 32'(rsp_err), 32'h1);
    check("r_grant_hold", 32'(grant_id), 32'd2);
    step();

    // Timeout on requester 3: m_start at t, rsp_valid at t+101.
    req_rw    = '0;
    req_valid = 4'b1000;
    req_addr[27:21] = 7'h33;
    #1;
    check("to_ready", 32'(req_ready), 32'h8);
    step();
    check("to_m_start", 32'(m_start), 32'd1);
    req_valid = '0;
    step(100);
    check("to_not_early", 32'(rsp_valid), 32'd0);
    step();
    check("to_rsp_valid", 32'(rsp_valid), 32'h8);
    check("to_rsp_err", 32'(rsp_err), 32'h2);
    check("to_rsp_rdata", 32'(rsp_rdata), 32'h00);
    step();
    check("to_idle", 32'(busy), 32'd0);

    // Round-robin with all requesters held valid.
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp_id;
      exp_id = k % 4;
      #1;
      check("rr_ready", 32'(req_ready), 32'd1 << exp_id);
      step();
      check("rr_grant", 32'(grant_id), 32'(exp_id));
      check("rr_m_start", 32'(m_start), 32'd1);
      step();
      m_done = 1'b1;
      step();
      m_done = 1'b0;
      check("rr_rsp_valid", 32'(rsp_valid), 32'd1 << exp_id);
      step();
    end
    req_valid = '0;

    // Engine busy blocks the grant; done lands on the expiry cycle.
    m_busy    = 1'b1;
    req_valid = 4'b0010;
    req_rw    = 4'b0010;
    #1;
    check("mb_ready_blocked", 32'(req_ready), 32'd0);
    step(3);
    check("mb_ready_still", 32'(req_ready), 32'd0);
    check("mb_no_start", 32'(m_start), 32'd0);
    check("mb_idle", 32'(busy), 32'd0);
    m_busy = 1'b0;
    #1;
    check("mb_ready_free", 32'(req_ready), 32'h2);
    step();
    check("mb_grant", 32'(grant_id), 32'd1);
    check("mb_m_start", 32'(m_start), 32'd1);
    req_valid = '0;
    step(100);
    m_done  = 1'b1;
    m_rdata = 8'h5A;
    check("edge_not_early", 32'(rsp_valid), 32'd0);
    step();
    m_done = 1'b0;
    check("edge_rsp_valid", 32'(rsp_valid), 32'h2);
    check("edge_rsp_err", 32'(rsp_err), 32'h0);
    check("edge_rsp_rdata", 32'(rsp_rdata), 32'h5A);
    step();

    // Stray m_done while idle is ignored.
    m_done  = 1'b1;
    m_rdata = 8'hEE;
    step();
    m_done = 1'b0;
    step();
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_rdata_hold", 32'(rsp_rdata), 32'h5A);

    // Reset in the middle of a wait drops the transaction.
    req_rw    = '0;
    req_valid = 4'b0100;
    req_addr[20:14] = 7'h2B;
    step();
    check("rw_grant", 32'(grant_id), 32'd2);
    req_valid = '0;
    step(5);
    rst_n = 1'b0;
    #1;
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_grant_zero", 32'(grant_id), 32'd0);
    check("rw_m_addr", 32'(m_addr), 32'd0);
    check("rw_rsp_rdata", 32'(rsp_rdata), 32'd0);
    step(2);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1001;
    req_addr[6:0]   = 7'h11;
    req_addr[27:21] = 7'h33;
    #1;
    check("rw_prio_ready", 32'(req_ready), 32'h1);
    step();
    check("rw_prio_grant", 32'(grant_id), 32'd0);
    check("rw_prio_addr", 32'(m_addr), 32'h11);
    req_valid = '0;
    step(3);
    check("rw_no_rsp", 32'(rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master engine between NUM_REQ local requesters. Each transaction is one addressed byte: 7-bit address, R/W bit, 8-bit data.
- Arbitrates round-robin and holds the grant for one transaction.
- Issues a start pulse to the engine, waits for completion or a timeout, and returns read data and error status to the granted requester.
- Sits between on-chip clients (sensor pollers, config loaders) and the single master driving SDA/SCL.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, grant index width; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 16'd50000, clk cycles allowed from m_start to m_done before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transaction request; held until accepted.
- req_ready  out  NUM_REQ  accept strobe, combinational; one-hot or zero.
- req_addr  in  NUM_REQ*7  packed slave addresses; requester i uses bits [7i+6:7i].
- req_rw  in  NUM_REQ  1 = read, 0 = write.
- req_wdata  in  NUM_REQ*8  packed write bytes; requester i uses bits [8i+7:8i].
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  out  8  read byte, shared; meaningful only with rsp_valid.
- rsp_err  out  2  status: 00 ok, 01 NACK, 10 timeout.
- grant_id  out  ID_W  index of the current or last granted requester.
- busy  out  1  high in any state except IDLE.
- m_start  out  1  one-cycle start pulse to the engine.
- m_addr  out  7  latched address to the engine.
- m_rw  out  1  latched R/W to the engine.
- m_wdata  out  8  latched write byte to the engine.
- m_busy  in  1  engine is occupied.
- m_done  in  1  one-cycle completion pulse from the engine.
- m_rdata  in  8  engine read byte; valid with m_done.
- m_ack_err  in  1  NACK seen; valid with m_done.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - m_start=0, m_addr=0, m_rw=0, m_wdata=0, busy=0, grant_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction drops the transaction silently. No rsp_valid is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Round-robin pick: first i with req_valid[i]=1, searching from last_grant+1 and wrapping modulo NUM_REQ.
  - req_ready[pick]=1 only when state=IDLE, m_busy=0 and at least one req_valid is set; otherwise all bits are 0.
  - On the handshake edge: latch req_addr/req_rw/req_wdata of pick into m_addr/m_rw/m_wdata; grant_id<=pick; go to ISSUE.
  - If m_busy=1, no grant is given and the FSM stays in IDLE.
- ISSUE:
  - m_start=1 for exactly this one cycle.
  - Load timeout counter with TIMEOUT; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - On m_done: rsp_rdata<=m_rw ? m_rdata : 8'h00; rsp_err<=m_ack_err ? 01 : 00; go to RESP.
  - On counter reaching 0 without m_done: rsp_err<=10, rsp_rdata<=0; go to RESP.
  - If m_done and counter==0 occur in the same cycle, m_done wins.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle; last_grant<=grant_id; go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next RESP.
- Latency:
  - Handshake edge to m_start high: 1 cycle.
  - m_done to rsp_valid: 1 cycle.
  - Back-to-back minimum of 4 cycles per transaction plus engine time.
- Latched m_* outputs hold stable from ISSUE through RESP. Requester inputs may change after req_ready without effect.
- An m_done pulse outside WAIT is ignored.
- A requester that drops req_valid before being granted is simply skipped.

Test Plan:
1. Single write: req0 valid, addr 7'h50, rw=0, wdata 8'hA5; engine m_done after 20 cycles with ack_err=0 -> m_start 1 cycle after handshake; m_addr=50, m_wdata=A5; rsp_valid[0] 1 cycle after m_done; rsp_err=00, rsp_rdata=00.
2. Read with NACK: req2 rw=1, addr 7'h1E; m_done with m_rdata=8'h3C, ack_err=1 -> rsp_valid[2]=1, rsp_rdata=3C, rsp_err=01, grant_id=2.
3. Round-robin fairness: all four req_valid held high continuously -> grant order 0,1,2,3,0; no requester granted twice in a row while others wait.
4. Timeout with TIMEOUT=16'd100: engine never pulses m_done -> rsp_valid exactly 101 cycles after m_start; rsp_err=10; FSM back in IDLE and the next request is granted.
5. Boundary cases:
   - m_busy=1 with req1 valid -> req_ready stays 0 until m_busy falls.
   - m_done asserted on the same cycle the counter hits 0 -> rsp_err=00.
6. Reset mid-WAIT: rst_n low for 2 cycles -> all outputs 0, no rsp_valid; after release req0 has priority over simultaneous req3.
